// File: rtl/sys_pe_if.sv
// sys_pe_if: control, operand and result bundle of one systolic processing element.
interface sys_pe_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32
);
  logic                 en;
  logic                 mode;
  logic                 clr;
  logic                 drain;
  logic                 w_load;
  logic [WIDTH-1:0]     a_in;
  logic                 a_vin;
  logic [WIDTH-1:0]     b_in;
  logic                 b_vin;
  logic [ACC_WIDTH-1:0] psum_in;
  logic [WIDTH-1:0]     a_out;
  logic                 a_vout;
  logic [WIDTH-1:0]     b_out;
  logic                 b_vout;
  logic [ACC_WIDTH-1:0] psum_out;
  logic [ACC_WIDTH-1:0] c_out;
  logic                 c_valid;
  logic                 ovf;

  modport master (
    output en, mode, clr, drain, w_load, a_in, a_vin, b_in, b_vin, psum_in,
    input  a_out, a_vout, b_out, b_vout, psum_out, c_out, c_valid, ovf
  );

  modport slave (
    input  en, mode, clr, drain, w_load, a_in, a_vin, b_in, b_vin, psum_in,
    output a_out, a_vout, b_out, b_vout, psum_out, c_out, c_valid, ovf
  );
endinterface

// File: rtl/sys_pe.sv
// sys_pe: systolic MAC element, output-stationary (local accumulator) or
// weight-stationary (held weight, partial sum flows through), with saturating sums.
module sys_pe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter bit SIGNED    = 1'b1
) (
  input logic      clk,
  input logic      rst,
  sys_pe_if.slave  pe
);
  localparam int AW = ACC_WIDTH;
  localparam int PW = 2 * WIDTH;
  localparam logic [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};

  // Returns {clamped, value}; the extra bit of s exposes overflow of the AW-bit sum.
  function automatic logic [AW:0] sat_add(input logic [AW-1:0] x, input logic [AW-1:0] y);
    logic [AW:0] s;
    if (SIGNED) begin
      s = {x[AW-1], x} + {y[AW-1], y};
      return (s[AW] != s[AW-1]) ? {1'b1, s[AW] ? SMIN : SMAX} : {1'b0, s[AW-1:0]};
    end
    s = {1'b0, x} + {1'b0, y};
    return s[AW] ? {1'b1, {AW{1'b1}}} : s;
  endfunction

  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_weight;
  logic [WIDTH-1:0] r_a;
  logic             r_av;
  logic [WIDTH-1:0] r_b;
  logic             r_bv;
  logic [AW-1:0]    r_psum;
  logic [AW-1:0]    r_c;
  logic             r_cv;
  logic             r_ovf;

  logic [WIDTH-1:0]        w_opb;
  logic signed [PW-1:0]    w_prod_s;
  logic [PW-1:0]           w_prod_u;
  logic [AW-1:0]           w_pext_s;
  logic [AW-1:0]           w_pext_u;
  logic [AW-1:0]           w_p;
  logic [AW-1:0]           w_base;
  logic                    w_fire;
  logic                    w_os_ov;
  logic [AW-1:0]           w_os_sum;
  logic                    w_ws_ov;
  logic [AW-1:0]           w_ws_sum;

  // Signed and unsigned products kept apart so neither inherits the other's signedness.
  assign w_opb    = pe.mode ? r_weight : pe.b_in;
  assign w_prod_s = PW'($signed(pe.a_in)) * PW'($signed(w_opb));
  assign w_prod_u = PW'(pe.a_in) * PW'(w_opb);
  assign w_pext_s = AW'(w_prod_s);
  assign w_pext_u = AW'(w_prod_u);
  assign w_p      = SIGNED ? w_pext_s : w_pext_u;

  assign w_base              = pe.clr ? '0 : r_acc;
  assign w_fire              = pe.a_vin & pe.b_vin;
  assign {w_os_ov, w_os_sum} = sat_add(w_base, w_p);
  assign {w_ws_ov, w_ws_sum} = sat_add(pe.psum_in, w_p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_weight <= '0;
      r_a      <= '0;
      r_av     <= 1'b0;
      r_b      <= '0;
      r_bv     <= 1'b0;
      r_psum   <= '0;
      r_c      <= '0;
      r_cv     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (pe.en) begin
      r_a  <= pe.a_in;
      r_av <= pe.a_vin;
      r_b  <= pe.b_in;
      r_bv <= pe.b_vin;
      r_cv <= ~pe.mode & pe.drain;
      if (!pe.mode) begin
        r_acc <= w_fire ? w_os_sum : w_base;
        if (pe.drain) r_c <= r_acc;
        r_ovf <= (r_ovf & ~pe.clr) | (w_fire & w_os_ov);
      end else begin
        if (pe.w_load & pe.b_vin) r_weight <= pe.b_in;
        r_psum <= pe.a_vin ? w_ws_sum : pe.psum_in;
        r_ovf  <= r_ovf | (pe.a_vin & w_ws_ov);
      end
    end
  end

  assign pe.a_out    = r_a;
  assign pe.a_vout   = r_av;
  assign pe.b_out    = r_b;
  assign pe.b_vout   = r_bv;
  assign pe.psum_out = r_psum;
  assign pe.c_out    = r_c;
  assign pe.c_valid  = r_cv;
  assign pe.ovf      = r_ovf;
endmodule

// File: doc/sys_pe.md
SYS_PE -- requirements
Module: sys_pe

Interface
REQ-001 WIDTH, 8, operand width in bits.
REQ-002 ACC_WIDTH, 32, accumulator/partial-sum width; SHALL be >= 2*WIDTH.
REQ-003 SIGNED, 1, 1 = two's-complement operands and sums, 0 = unsigned.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  global advance; 0 = stall, every register holds.
REQ-007 mode  in  1  0 = output-stationary (OS), 1 = weight-stationary (WS).
REQ-008 clr  in  1  OS: restart accumulation from 0; also clears ovf.
REQ-009 drain  in  1  OS: copy accumulator to c_out.
REQ-010 w_load  in  1  WS: load weight register from b_in.
REQ-011 a_in  in  WIDTH  activation operand.
REQ-012 a_vin  in  1  a_in valid.
REQ-013 b_in  in  WIDTH  weight/operand.
REQ-014 b_vin  in  1  b_in valid.
REQ-015 psum_in  in  ACC_WIDTH  WS partial sum from upstream PE.
REQ-016 a_out / a_vout  out  WIDTH / 1  registered a_in / a_vin.
REQ-017 b_out / b_vout  out  WIDTH / 1  registered b_in / b_vin.
REQ-018 psum_out  out  ACC_WIDTH  WS partial sum to downstream PE.
REQ-019 c_out  out  ACC_WIDTH  drained OS result.
REQ-020 c_valid  out  1  c_out valid, one en-cycle pulse.
REQ-021 ovf  out  1  sticky saturation flag.

Function
REQ-022 en=0 SHALL freeze all registers and outputs; every rule below applies only on cycles with en=1.
REQ-023 a_out, a_vout, b_out, b_vout SHALL equal the previous en-cycle's inputs (1-cycle latency) in both modes, independent of valids.
REQ-024 Product p = a_in*b_in (OS) or a_in*weight (WS), 2*WIDTH wide, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH.
REQ-025 All additions SHALL saturate: SIGNED=1 clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; SIGNED=0 clamp to 2^ACC_WIDTH-1; any clamp sets ovf.
REQ-026 OS: base = clr ? 0 : acc; if a_vin&b_vin, acc <= sat(base+p); else acc <= base.
REQ-027 OS drain: c_out <= acc register value before this cycle's update; c_valid=1 next cycle, 0 on following en-cycle.
REQ-028 drain and clr same cycle: c_out gets old acc, new tile starts from 0 (+p if valid), enabling back-to-back tiles with no bubble.
REQ-029 ovf cleared by clr (same edge; re-set if that cycle's add clamps); otherwise held until rst.
REQ-030 WS: w_load&b_vin loads weight <= b_in; w_load without b_vin ignored.
REQ-031 WS: psum_out <= a_vin ? sat(psum_in+p) : psum_in; acc, c_out untouched.
REQ-032 OS: psum_out holds; w_load ignored; WS: clr/drain ignored.
REQ-033 Mode change SHALL not clear acc, weight or ovf.

Reset
REQ-034 rst=1 SHALL immediately zero acc, weight, a_out, a_vout, b_out, b_vout, psum_out, c_out, c_valid, ovf, including mid-operation; resumes on first edge after deassert.

Verification
REQ-035 OS, SIGNED=1: a=3,b=4 valid 4 cycles, then drain -> c_out=48, c_valid high exactly 1 cycle; a_out=3 one cycle after each input.
REQ-036 OS signed: a=0x80 (-128), b=0x7F after clr -> acc=-16256; SIGNED=0 same inputs -> 16256.
REQ-037 ACC_WIDTH=16: a=b=0x80 two cycles -> 16384 then clamp 32767, ovf=1; clr -> acc 0, ovf 0.
REQ-038 WS: w_load with b_in=5, then a_in=2, psum_in=10 -> psum_out=20 next cycle; weight held over 3 further vectors.
REQ-039 acc=48, drain+clr with a=1,b=1 valid -> c_out=48, acc=1.
REQ-040 en=0 three cycles mid-stream -> all outputs frozen; rst pulse between edges -> all outputs 0 before next edge.
